// File: rtl/id_ex_operand_reg.sv
// rtl/id_ex_operand_reg.sv - ID/EX pipeline register with MEM/WB operand forwarding
// Holds decoded operands for the EX units; refreshes held rs/rt from WB while stalled.
module id_ex_operand_reg #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [WIDTH-1:0] id_pc,
  input  logic [WIDTH-1:0] id_instr,
  input  logic [WIDTH-1:0] id_rs_val,
  input  logic [WIDTH-1:0] id_rt_val,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [RA_W-1:0]  id_rs_addr,
  input  logic [RA_W-1:0]  id_rt_addr,
  input  logic [RA_W-1:0]  id_wa,
  input  logic [OP_W-1:0]  id_alu_op,
  input  logic             id_bsel,
  input  logic             id_reg_we,
  input  logic             mem_we,
  input  logic [RA_W-1:0]  mem_wa,
  input  logic [WIDTH-1:0] mem_wd,
  input  logic             wb_we,
  input  logic [RA_W-1:0]  wb_wa,
  input  logic [WIDTH-1:0] wb_wd,
  output logic             ex_valid,
  output logic [WIDTH-1:0] ex_pc,
  output logic [WIDTH-1:0] ex_instr,
  output logic [WIDTH-1:0] ex_A,
  output logic [WIDTH-1:0] ex_B,
  output logic [WIDTH-1:0] ex_rt_fwd,
  output logic [RA_W-1:0]  ex_wa,
  output logic [OP_W-1:0]  ex_alu_op,
  output logic             ex_reg_we
);

  logic             valid_q,   valid_d;
  logic [WIDTH-1:0] pc_q,      pc_d;
  logic [WIDTH-1:0] instr_q,   instr_d;
  logic [WIDTH-1:0] rs_val_q,  rs_val_d;
  logic [WIDTH-1:0] rt_val_q,  rt_val_d;
  logic [WIDTH-1:0] imm_q,     imm_d;
  logic [RA_W-1:0]  rs_addr_q, rs_addr_d;
  logic [RA_W-1:0]  rt_addr_q, rt_addr_d;
  logic [RA_W-1:0]  wa_q,      wa_d;
  logic [OP_W-1:0]  alu_op_q,  alu_op_d;
  logic             bsel_q,    bsel_d;
  logic             reg_we_q,  reg_we_d;

  function automatic logic wb_hit(input logic [RA_W-1:0] addr);
    return wb_we && (wb_wa != '0) && (wb_wa == addr);
  endfunction

  function automatic logic mem_hit(input logic [RA_W-1:0] addr);
    return mem_we && (mem_wa != '0) && (mem_wa == addr);
  endfunction

  function automatic logic [WIDTH-1:0] fwd(input logic [RA_W-1:0]  addr,
                                           input logic [WIDTH-1:0] stored);
    if (mem_hit(addr))
      return mem_wd;
    else if (wb_hit(addr))
      return wb_wd;
    else
      return stored;
  endfunction

  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    rs_val_d  = rs_val_q;
    rt_val_d  = rt_val_q;
    imm_d     = imm_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    wa_d      = wa_q;
    alu_op_d  = alu_op_q;
    bsel_d    = bsel_q;
    reg_we_d  = reg_we_q;
    if (flush) begin
      // Addresses clear too, so a bubble can never pick up a forwarded value.
      valid_d   = 1'b0;
      pc_d      = '0;
      instr_d   = '0;
      rs_val_d  = '0;
      rt_val_d  = '0;
      imm_d     = '0;
      rs_addr_d = '0;
      rt_addr_d = '0;
      wa_d      = '0;
      alu_op_d  = '0;
      bsel_d    = 1'b0;
      reg_we_d  = 1'b0;
    end else if (stall) begin
      if (wb_hit(rs_addr_q)) rs_val_d = wb_wd;
      if (wb_hit(rt_addr_q)) rt_val_d = wb_wd;
    end else begin
      valid_d   = id_valid;
      pc_d      = id_pc;
      instr_d   = id_instr;
      rs_val_d  = wb_hit(id_rs_addr) ? wb_wd : id_rs_val;
      rt_val_d  = wb_hit(id_rt_addr) ? wb_wd : id_rt_val;
      imm_d     = id_imm;
      rs_addr_d = id_rs_addr;
      rt_addr_d = id_rt_addr;
      wa_d      = id_wa;
      alu_op_d  = id_alu_op;
      bsel_d    = id_bsel;
      reg_we_d  = id_reg_we & id_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      instr_q   <= '0;
      rs_val_q  <= '0;
      rt_val_q  <= '0;
      imm_q     <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      wa_q      <= '0;
      alu_op_q  <= '0;
      bsel_q    <= 1'b0;
      reg_we_q  <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      rs_val_q  <= rs_val_d;
      rt_val_q  <= rt_val_d;
      imm_q     <= imm_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      wa_q      <= wa_d;
      alu_op_q  <= alu_op_d;
      bsel_q    <= bsel_d;
      reg_we_q  <= reg_we_d;
    end
  end

  assign ex_valid  = valid_q;
  assign ex_pc     = pc_q;
  assign ex_instr  = instr_q;
  assign ex_wa     = wa_q;
  assign ex_alu_op = alu_op_q;
  assign ex_reg_we = reg_we_q & valid_q;
  assign ex_A      = fwd(rs_addr_q, rs_val_q);
  assign ex_rt_fwd = fwd(rt_addr_q, rt_val_q);
  assign ex_B      = bsel_q ? imm_q : ex_rt_fwd;

endmodule

// File: tb/tb_id_ex_operand_reg.sv
// tb/tb_id_ex_operand_reg.sv - directed vectors, corner sequences and random run vs reference
module tb_id_ex_operand_reg;

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid, id_bsel, id_reg_we;
  logic [31:0] id_pc, id_instr, id_rs_val, id_rt_val, id_imm;
  logic [4:0]  id_rs_addr, id_rt_addr, id_wa;
  logic [3:0]  id_alu_op;
  logic        mem_we, wb_we;
  logic [4:0]  mem_wa, wb_wa;
  logic [31:0] mem_wd, wb_wd;
  logic        ex_valid, ex_reg_we;
  logic [31:0] ex_pc, ex_instr, ex_A, ex_B, ex_rt_fwd;
  logic [4:0]  ex_wa;
  logic [3:0]  ex_alu_op;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_operand_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_wa(id_wa),
    .id_alu_op(id_alu_op), .id_bsel(id_bsel), .id_reg_we(id_reg_we),
    .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr),
    .ex_A(ex_A), .ex_B(ex_B), .ex_rt_fwd(ex_rt_fwd),
    .ex_wa(ex_wa), .ex_alu_op(ex_alu_op), .ex_reg_we(ex_reg_we)
  );

  // Reference picture of what the stage holds, as an instruction record.
  typedef struct {
    logic        valid;
    logic [31:0] pc, instr, rs_val, rt_val, imm;
    logic [4:0]  rs_addr, rt_addr, wa;
    logic [3:0]  op;
    logic        bsel, we;
  } stage_t;
  stage_t m;

  typedef struct {
    logic        rst, stl, fl, valid;
    logic [31:0] pc, instr;
    logic [4:0]  rs_addr;
    logic [31:0] rs_val;
    logic [4:0]  rt_addr;
    logic [31:0] rt_val, imm;
    logic [4:0]  wa;
    logic [3:0]  op;
    logic        bsel, we, mwe;
    logic [4:0]  mwa;
    logic [31:0] mwd;
    logic        wwe;
    logic [4:0]  wwa;
    logic [31:0] wwd;
    logic        e_valid;
    logic [31:0] e_pc, e_instr, e_a, e_b, e_rt;
    logic        e_we;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] v);
    if (mem_we && mem_wa != 0 && mem_wa == a) return mem_wd;
    if (wb_we && wb_wa != 0 && wb_wa == a) return wb_wd;
    return v;
  endfunction

  function automatic logic wb_match(input logic [4:0] a);
    return wb_we && wb_wa != 0 && wb_wa == a;
  endfunction

  // Advance the reference and the DUT by one clock edge on the current inputs.
  task automatic tick();
    if (reset || flush) begin
      m = '{default: '0};
    end else if (stall) begin
      if (wb_match(m.rs_addr)) m.rs_val = wb_wd;
      if (wb_match(m.rt_addr)) m.rt_val = wb_wd;
    end else begin
      m.valid   = id_valid;
      m.pc      = id_pc;
      m.instr   = id_instr;
      m.rs_addr = id_rs_addr;
      m.rt_addr = id_rt_addr;
      m.rs_val  = wb_match(id_rs_addr) ? wb_wd : id_rs_val;
      m.rt_val  = wb_match(id_rt_addr) ? wb_wd : id_rt_val;
      m.imm     = id_imm;
      m.wa      = id_wa;
      m.op      = id_alu_op;
      m.bsel    = id_bsel;
      m.we      = id_reg_we & id_valid;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    logic [31:0] rt_exp;
    rt_exp = ref_fwd(m.rt_addr, m.rt_val);
    chk("rnd_valid", {31'b0, ex_valid}, {31'b0, m.valid});
    chk("rnd_pc", ex_pc, m.pc);
    chk("rnd_instr", ex_instr, m.instr);
    chk("rnd_A", ex_A, ref_fwd(m.rs_addr, m.rs_val));
    chk("rnd_rt_fwd", ex_rt_fwd, rt_exp);
    chk("rnd_B", ex_B, m.bsel ? m.imm : rt_exp);
    chk("rnd_wa", {27'b0, ex_wa}, {27'b0, m.wa});
    chk("rnd_op", {28'b0, ex_alu_op}, {28'b0, m.op});
    chk("rnd_we", {31'b0, ex_reg_we}, {31'b0, m.we & m.valid});
  endtask

  task automatic idle();
    reset = 0; stall = 0; flush = 0; id_valid = 0; id_bsel = 0; id_reg_we = 0;
    id_pc = 0; id_instr = 0; id_rs_val = 0; id_rt_val = 0; id_imm = 0;
    id_rs_addr = 0; id_rt_addr = 0; id_wa = 0; id_alu_op = 0;
    mem_we = 0; mem_wa = 0; mem_wd = 0; wb_we = 0; wb_wa = 0; wb_wd = 0;
  endtask

  task automatic load(input logic [31:0] pc, input logic [4:0] rs, input logic [31:0] rsv,
                      input logic [4:0] rt, input logic [31:0] rtv,
                      input logic bsel, input logic [31:0] imm);
    id_valid = 1; id_reg_we = 1; id_pc = pc; id_instr = pc ^ 32'h0F0F_0000;
    id_rs_addr = rs; id_rs_val = rsv; id_rt_addr = rt; id_rt_val = rtv;
    id_bsel = bsel; id_imm = imm; id_wa = 5'd9; id_alu_op = 4'd2;
  endtask

  initial begin
    idle();
    reset = 1;
    tick();

    // Field order: rst stl fl valid pc instr rs_addr rs_val rt_addr rt_val imm wa op bsel we
    //              mwe mwa mwd wwe wwa wwd | e_valid e_pc e_instr e_a e_b e_rt e_we
    vecs[0] = '{1,0,0, 1,32'hFFFF_FFFF,32'hFFFF_FFFF, 5'h1f,32'hFFFF_FFFF,5'h1f,32'hFFFF_FFFF,
                32'hFFFF_FFFF,5'h1f,4'hf,1,1, 0,0,0, 0,0,0, 0,0,0,0,0,0,0};
    vecs[1] = '{0,0,0, 1,32'h100,32'h1234, 5'd3,32'h10,5'd4,32'h20,32'h7,5'd2,4'd5,0,1,
                0,0,0, 0,0,0, 1,32'h100,32'h1234,32'h10,32'h20,32'h20,1};
    vecs[2] = '{0,0,0, 1,32'h200,32'h2222, 5'd5,32'h11,5'd6,32'h22,32'h3,5'd7,4'd1,0,1,
                0,0,0, 1,5'd5,32'h99, 1,32'h200,32'h2222,32'h99,32'h22,32'h22,1};
    vecs[3] = '{0,1,0, 0,32'hDEAD,32'hBEEF, 5'd1,32'h1,5'd2,32'h2,32'h3,5'd4,4'd9,1,0,
                0,0,0, 0,0,0, 1,32'h200,32'h2222,32'h99,32'h22,32'h22,1};
    vecs[4] = '{0,1,1, 1,32'h300,32'h3333, 5'd3,32'h5,5'd4,32'h6,32'h7,5'd8,4'd3,0,1,
                0,0,0, 0,0,0, 0,0,0,0,0,0,0};

    for (int i = 0; i < 5; i++) begin
      reset = vecs[i].rst; stall = vecs[i].stl; flush = vecs[i].fl;
      id_valid = vecs[i].valid; id_pc = vecs[i].pc; id_instr = vecs[i].instr;
      id_rs_addr = vecs[i].rs_addr; id_rs_val = vecs[i].rs_val;
      id_rt_addr = vecs[i].rt_addr; id_rt_val = vecs[i].rt_val; id_imm = vecs[i].imm;
      id_wa = vecs[i].wa; id_alu_op = vecs[i].op; id_bsel = vecs[i].bsel;
      id_reg_we = vecs[i].we; mem_we = vecs[i].mwe; mem_wa = vecs[i].mwa; mem_wd = vecs[i].mwd;
      wb_we = vecs[i].wwe; wb_wa = vecs[i].wwa; wb_wd = vecs[i].wwd;
      tick();
      chk($sformatf("vec%0d_valid", i), {31'b0, ex_valid}, {31'b0, vecs[i].e_valid});
      chk($sformatf("vec%0d_pc", i), ex_pc, vecs[i].e_pc);
      chk($sformatf("vec%0d_instr", i), ex_instr, vecs[i].e_instr);
      chk($sformatf("vec%0d_A", i), ex_A, vecs[i].e_a);
      chk($sformatf("vec%0d_B", i), ex_B, vecs[i].e_b);
      chk($sformatf("vec%0d_rt_fwd", i), ex_rt_fwd, vecs[i].e_rt);
      chk($sformatf("vec%0d_we", i), {31'b0, ex_reg_we}, {31'b0, vecs[i].e_we});
    end

    // MEM beats WB; dropping MEM exposes WB; register 0 never forwards.
    idle();
    load(32'h400, 5'd3, 32'h10, 5'd4, 32'h20, 0, 32'h0);
    mem_we = 1; mem_wa = 5'd3; mem_wd = 32'hAA;
    wb_we = 1; wb_wa = 5'd3; wb_wd = 32'hBB;
    tick();
    chk("t3_mem_prio", ex_A, 32'hAA);
    mem_we = 0;
    #1;
    chk("t3_wb_fwd", ex_A, 32'hBB);
    idle();
    load(32'h404, 5'd0, 32'h0, 5'd0, 32'h0, 0, 32'h0);
    mem_we = 1; mem_wa = 5'd0; mem_wd = 32'hCC;
    wb_we = 1; wb_wa = 5'd0; wb_wd = 32'hDD;
    tick();
    chk("t3_r0_A", ex_A, 32'h0);
    chk("t3_r0_rt", ex_rt_fwd, 32'h0);

    // Three-cycle stall with the rt producer retiring mid-hold.
    idle();
    load(32'h500, 5'd3, 32'h10, 5'd4, 32'h20, 0, 32'h0);
    tick();
    load(32'h600, 5'd7, 32'h77, 5'd8, 32'h88, 1, 32'h1);
    stall = 1;
    tick();
    wb_we = 1; wb_wa = 5'd4; wb_wd = 32'h55;
    tick();
    wb_we = 0;
    tick();
    chk("t4_pc_held", ex_pc, 32'h500);
    chk("t4_instr_held", ex_instr, 32'h500 ^ 32'h0F0F_0000);
    chk("t4_rt_refresh", ex_rt_fwd, 32'h55);
    chk("t4_B_refresh", ex_B, 32'h55);
    chk("t4_A_held", ex_A, 32'h10);
    stall = 0;
    load(32'h700, 5'd3, 32'h10, 5'd4, 32'h20, 1, 32'h7);
    tick();
    chk("t4_B_imm", ex_B, 32'h7);
    chk("t4_rt_with_imm", ex_rt_fwd, 32'h20);

    // Reset while held clears everything.
    stall = 1; reset = 1;
    tick();
    chk("rst_stall_valid", {31'b0, ex_valid}, 32'h0);
    chk("rst_stall_pc", ex_pc, 32'h0);
    chk("rst_stall_B", ex_B, 32'h0);

    // Random traffic against the reference; narrow address range to provoke forwarding.
    idle();
    for (int c = 0; c < 400; c++) begin
      reset      = ($urandom_range(0, 39) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      id_valid   = 1'($urandom);
      id_pc      = $urandom;
      id_instr   = $urandom;
      id_rs_val  = $urandom;
      id_rt_val  = $urandom;
      id_imm     = $urandom;
      id_rs_addr = 5'($urandom_range(0, 3));
      id_rt_addr = 5'($urandom_range(0, 3));
      id_wa      = 5'($urandom);
      id_alu_op  = 4'($urandom);
      id_bsel    = 1'($urandom);
      id_reg_we  = 1'($urandom);
      mem_we     = 1'($urandom);
      mem_wa     = 5'($urandom_range(0, 3));
      mem_wd     = $urandom;
      wb_we      = 1'($urandom);
      wb_wa      = 5'($urandom_range(0, 3));
      wb_wd      = $urandom;
      #1;
      check_model();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
